// File: rtl/mips_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// quotient lands in LO and remainder in HI with a start/busy/done handshake.
module mips_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz_pend;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_accept;
    logic             w_dsr_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_fit;
    logic [WIDTH-1:0] w_sub;
    logic             w_last;
    logic             w_fix_hold;

    // The done cycle is still blocked so a start there is not taken.
    assign w_accept   = start && (r_state == IDLE) && !r_done;
    assign w_dsr_zero = (divisor == '0);
    assign w_dvd_mag  = (signed_op && dividend[WIDTH-1]) ? WIDTH'(~dividend + WIDTH'(1)) : dividend;
    assign w_dsr_mag  = (signed_op && divisor[WIDTH-1])  ? WIDTH'(~divisor + WIDTH'(1))  : divisor;

    // Partial remainder stays below the divisor, so the trial difference fits in WIDTH bits.
    assign w_shift    = {r_prem, r_dvd[WIDTH-1]};
    assign w_fit      = (w_shift >= {1'b0, r_dsr});
    assign w_sub      = WIDTH'(w_shift[WIDTH-1:0] - r_dsr);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // Divide-by-zero spends one alignment cycle in FIX so done lands two edges after accept.
    assign w_fix_hold = r_dbz_pend && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_dsr_zero ? FIX : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                if (!w_fix_hold) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prem     <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy     <= 1'b1;
                        r_dbz      <= 1'b0;
                        r_cnt      <= '0;
                        r_prem     <= '0;
                        r_neg_q    <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r    <= signed_op && dividend[WIDTH-1];
                        r_dbz_pend <= w_dsr_zero;
                        r_dvd      <= w_dsr_zero ? dividend : w_dvd_mag;
                        r_dsr      <= w_dsr_mag;
                    end
                end
                RUN: begin
                    r_prem <= w_fit ? w_sub : w_shift[WIDTH-1:0];
                    r_dvd  <= {r_dvd[WIDTH-2:0], w_fit};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    if (w_fix_hold) begin
                        r_cnt <= CNT_W'(1);
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        if (r_dbz_pend) begin
                            r_quot <= '1;
                            r_rem  <= r_dvd;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_quot <= r_neg_q ? WIDTH'(~r_dvd + WIDTH'(1))  : r_dvd;
                            r_rem  <= r_neg_r ? WIDTH'(~r_prem + WIDTH'(1)) : r_prem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mips_divider.sv
// Directed and randomized checks of mips_divider results, latency and handshake,
// with expected results queued at issue and compared when done pulses.
module tb_mips_divider;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         start     = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend  = '0;
    logic [W-1:0] divisor   = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    int   lat_q[$];

    mips_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz;
        return e;
    endfunction

    // Reference: SV division truncates toward zero, matching MIPS DIV semantics.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (b == '0)                                    return mk('1, a, 1'b1);
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return mk(32'h8000_0000, '0, 1'b0);
        if (s) return mk(W'($signed(a) / $signed(b)), W'($signed(a) % $signed(b)), 1'b0);
        return mk(a / b, a % b, 1'b0);
    endfunction

    task automatic div_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input exp_t e, input int lat, input bit poke);
        exp_t got;
        int   cyc;
        int   busy_n;
        @(negedge clk);
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        sb.push_back(e);
        lat_q.push_back(lat);
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        cyc = 0;
        busy_n = busy ? 1 : 0;
        while (!done && cyc < 200) begin
            if (poke && cyc == 5) begin
                start = 1'b1; signed_op = ~s; dividend = 32'd9; divisor = 32'd4;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_n++;
        end
        start = 1'b0;
        got = sb.pop_front();
        check("latency", W'(cyc), W'(lat_q.pop_front()));
        check("busy_cycles", W'(busy_n), W'(lat));
        check("quotient", quotient, got.q);
        check("remainder", remainder, got.r);
        check("div_by_zero", W'(div_by_zero), W'(got.dbz));
        if (poke) begin
            dividend = 32'd1; divisor = 32'd1; signed_op = 1'b0; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse", W'(done), '0);
        if (poke) begin
            check("start_in_done_busy", W'(busy), '0);
            check("hold_quotient", quotient, got.q);
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        bit           seen;

        #2 rst_n = 1'b0;
        #10;
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        check("rst_dbz", W'(div_by_zero), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        div_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0), 33, 1'b0);
        div_op(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), 33, 1'b0);
        div_op(32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFD, 32'd1, 1'b0), 33, 1'b0);
        div_op(32'hFFFF_FFFF, 32'h10, 1'b0, mk(32'h0FFF_FFFF, 32'hF, 1'b0), 33, 1'b0);
        div_op(32'hFFFF_FFFF, 32'h10, 1'b1, mk(32'h0, 32'hFFFF_FFFF, 1'b0), 33, 1'b0);
        div_op(32'd1234, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'd1234, 1'b1), 2, 1'b0);
        div_op(32'd10, 32'd3, 1'b0, mk(32'd3, 32'd1, 1'b0), 33, 1'b0);
        div_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0), 33, 1'b1);
        div_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'h0, 1'b0), 33, 1'b0);

        // Abort a run with reset at iteration 10.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        check("abort_quotient", quotient, '0);
        check("abort_remainder", remainder, '0);
        check("abort_dbz", W'(div_by_zero), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_activity", W'(seen), '0);
        div_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0), 33, 1'b0);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? '0 : ((i % 2 == 0) ? W'($urandom_range(1, 65535)) : W'($urandom));
            if (b == '0 && i != 3) b = 32'd5;
            s = (i % 3) != 0;
            div_op(a, b, s, model(a, b, s), (b == '0) ? 2 : 33, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
